// File: rtl/line_memory_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : line_memory_responder
//  Description : Line-granular backing store answering cache refills and
//                write-backs after a fixed access latency. Defining
//                LINE_MEM_STATS_EN adds read/write completion counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_memory_responder #(
    parameter int LINE_SIZE = 16,
    parameter int NUM_LINES = 256,
    parameter int DELAY     = 50
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   is_input_valid,
    input  logic [31:0]            addr,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [8*LINE_SIZE-1:0] din,
    output logic                   is_output_valid,
    output logic [8*LINE_SIZE-1:0] dout,
    output logic                   mem_ready
`ifdef LINE_MEM_STATS_EN
    ,
    output logic [31:0]            num_reads,
    output logic [31:0]            num_writes
`endif
);

    localparam int c_LINE_BITS = 8 * LINE_SIZE;
    localparam int c_WPL       = LINE_SIZE / 4;
    localparam int c_WOFF      = $clog2(c_WPL);
    localparam int c_IDX_W     = $clog2(NUM_LINES);
    localparam int c_CNT_W     = (DELAY > 1) ? $clog2(DELAY) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(DELAY - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]             r_state;
    logic [c_CNT_W-1:0]     r_count;
    logic                   r_op_read;
    logic [c_IDX_W-1:0]     r_idx;
    logic [c_LINE_BITS-1:0] r_din;
    logic [c_LINE_BITS-1:0] r_mem [NUM_LINES];

    logic w_accept;
    logic w_complete;
    logic w_unused_addr;

    // Tag bits above the index and word-offset bits select nothing here.
    assign w_unused_addr = ^addr;

    assign mem_ready  = (r_state != c_BUSY);
    assign w_accept   = mem_ready && is_input_valid && (mem_read ^ mem_write);
    assign w_complete = (r_state == c_BUSY) && (r_count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= c_IDLE;
            r_count         <= '0;
            r_op_read       <= 1'b0;
            r_idx           <= '0;
            r_din           <= '0;
            dout            <= '0;
            is_output_valid <= 1'b0;
        end else begin
            is_output_valid <= 1'b0;
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (w_accept) begin
                        r_state   <= c_BUSY;
                        r_count   <= c_CNT_LOAD;
                        r_op_read <= mem_read;
                        r_idx     <= addr[c_WOFF +: c_IDX_W];
                        r_din     <= din;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                c_BUSY: begin
                    if (w_complete) begin
                        r_state <= c_DONE;
                        if (r_op_read) begin
                            dout            <= r_mem[r_idx];
                            is_output_valid <= 1'b1;
                        end
                    end else begin
                        r_count <= r_count - c_CNT_W'(1);
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Array is never cleared; reset only suppresses an in-flight commit.
    always_ff @(posedge clk) begin
        if (!reset && w_complete && !r_op_read) begin
            r_mem[r_idx] <= r_din;
        end
    end

`ifdef LINE_MEM_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            num_reads  <= '0;
            num_writes <= '0;
        end else if (w_complete) begin
            if (r_op_read) begin
                num_reads <= num_reads + 32'd1;
            end else begin
                num_writes <= num_writes + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_line_memory_responder.sv
`default_nettype none
`timescale 1ns/1ps
// Directed bench for line_memory_responder at DELAY=4: table of line ops plus
// hand-written held-request, illegal-request and reset-abort sequences.
module tb_line_memory_responder;

    localparam int c_DLY = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         is_input_valid;
    logic [31:0]  addr;
    logic         mem_read;
    logic         mem_write;
    logic [127:0] din;
    logic         is_output_valid;
    logic [127:0] dout;
    logic         mem_ready;
`ifdef LINE_MEM_STATS_EN
    logic [31:0]  num_reads;
    logic [31:0]  num_writes;
`endif

    int n_checks = 0;
    int n_err    = 0;

    line_memory_responder #(
        .LINE_SIZE (16),
        .NUM_LINES (256),
        .DELAY     (c_DLY)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .is_input_valid  (is_input_valid),
        .addr            (addr),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .din             (din),
        .is_output_valid (is_output_valid),
        .dout            (dout),
        .mem_ready       (mem_ready)
`ifdef LINE_MEM_STATS_EN
        ,
        .num_reads       (num_reads),
        .num_writes      (num_writes)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rd;
        logic [31:0]  a;
        logic [127:0] d;
        logic [127:0] exp_dout;
    } vec_t;

    localparam logic [127:0] c_P = 128'h0011_2233_4455_6677_DEAD_BEEF_0123_4567;
    localparam logic [127:0] c_A = 128'hAAAA_AAAA_1111_1111_AAAA_AAAA_1111_1111;
    localparam logic [127:0] c_B = 128'hBBBB_BBBB_2222_2222_BBBB_BBBB_2222_2222;
    localparam logic [127:0] c_C = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    localparam logic [127:0] c_E = 128'hEEEE_0000_EEEE_0000_5555_6666_7777_8888;
    localparam logic [127:0] c_D = 128'hD0D0_D0D0_D0D0_D0D0_D0D0_D0D0_D0D0_D0D0;
    localparam logic [127:0] c_F = 128'hF00D_CAFE_F00D_CAFE_F00D_CAFE_F00D_CAFE;

    vec_t tbl [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete request: accept, DELAY busy cycles, the DONE cycle, then idle.
    task automatic op(input string tag, input logic rd, input logic [31:0] a,
                      input logic [127:0] d, input logic [127:0] exp);
        chk({tag, " ready_pre"}, 128'(mem_ready), 128'd1);
        is_input_valid = 1'b1;
        mem_read       = rd;
        mem_write      = !rd;
        addr           = a;
        din            = d;
        tick();
        is_input_valid = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        for (int i = 0; i < c_DLY; i++) begin
            chk({tag, " busy_ready"}, 128'(mem_ready), 128'd0);
            chk({tag, " busy_valid"}, 128'(is_output_valid), 128'd0);
            tick();
        end
        chk({tag, " done_ready"}, 128'(mem_ready), 128'd1);
        chk({tag, " done_valid"}, 128'(is_output_valid), 128'(rd));
        chk({tag, " dout"}, dout, exp);
        tick();
        chk({tag, " valid_after"}, 128'(is_output_valid), 128'd0);
    endtask

    initial begin
        tbl[0] = '{1'b0, 32'h0000_0040, c_P, 128'd0};
        tbl[1] = '{1'b1, 32'h0000_0043, '0,  c_P};
        tbl[2] = '{1'b0, 32'h0000_0000, c_A, c_P};
        tbl[3] = '{1'b0, 32'h0000_0400, c_B, c_P};
        tbl[4] = '{1'b1, 32'h0000_0000, '0,  c_B};
        tbl[5] = '{1'b0, 32'h0000_001C, c_C, c_B};
        tbl[6] = '{1'b1, 32'h0000_001C, '0,  c_C};
        tbl[7] = '{1'b0, 32'h0000_0014, c_E, c_C};
        tbl[8] = '{1'b1, 32'hFFFF_FC40, '0,  c_P};
        tbl[9] = '{1'b1, 32'h0000_0014, '0,  c_E};

        reset          = 1'b1;
        is_input_valid = 1'b0;
        addr           = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        din            = '0;
        repeat (3) tick();
        reset = 1'b0;
        chk("reset ready", 128'(mem_ready), 128'd1);
        chk("reset valid", 128'(is_output_valid), 128'd0);
        chk("reset dout", dout, 128'd0);
`ifdef LINE_MEM_STATS_EN
        chk("reset num_reads", 128'(num_reads), 128'd0);
        chk("reset num_writes", 128'(num_writes), 128'd0);
`endif

        for (int i = 0; i < 10; i++) begin
            op($sformatf("vec%0d", i), tbl[i].rd, tbl[i].a, tbl[i].d, tbl[i].exp_dout);
        end

        // Second request held through BUSY is taken only at the DONE edge.
        is_input_valid = 1'b1;
        mem_read       = 1'b1;
        mem_write      = 1'b0;
        addr           = 32'h0000_0040;
        tick();
        addr = 32'h0000_001C;
        for (int i = 0; i < c_DLY; i++) begin
            chk("held busy_ready", 128'(mem_ready), 128'd0);
            tick();
        end
        chk("held done1_valid", 128'(is_output_valid), 128'd1);
        chk("held done1_dout", dout, c_P);
        chk("held done1_ready", 128'(mem_ready), 128'd1);
        tick();
        is_input_valid = 1'b0;
        mem_read       = 1'b0;
        for (int i = 0; i < c_DLY; i++) begin
            chk("held2 busy_ready", 128'(mem_ready), 128'd0);
            chk("held2 busy_valid", 128'(is_output_valid), 128'd0);
            tick();
        end
        chk("held done2_valid", 128'(is_output_valid), 128'd1);
        chk("held done2_dout", dout, c_C);
        tick();

        // Both and neither op bits: must be ignored.
        is_input_valid = 1'b1;
        mem_read       = 1'b1;
        mem_write      = 1'b1;
        addr           = 32'h0000_0040;
        din            = '1;
        tick();
        chk("both ready", 128'(mem_ready), 128'd1);
        chk("both valid", 128'(is_output_valid), 128'd0);
        tick();
        chk("both ready2", 128'(mem_ready), 128'd1);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        tick();
        chk("neither ready", 128'(mem_ready), 128'd1);
        chk("neither valid", 128'(is_output_valid), 128'd0);
        tick();
        is_input_valid = 1'b0;
        chk("neither valid2", 128'(is_output_valid), 128'd0);
        op("illegal_readback", 1'b1, 32'h0000_0040, '0, c_P);

        // Reset while a write to idx 5 has counter=2.
        is_input_valid = 1'b1;
        mem_write      = 1'b1;
        addr           = 32'h0000_0014;
        din            = c_D;
        tick();
        is_input_valid = 1'b0;
        mem_write      = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort ready", 128'(mem_ready), 128'd1);
        chk("abort valid", 128'(is_output_valid), 128'd0);
        chk("abort dout", dout, 128'd0);
`ifdef LINE_MEM_STATS_EN
        chk("abort num_writes", 128'(num_writes), 128'd0);
`endif
        repeat (c_DLY) begin
            tick();
            chk("abort no_resp", 128'(is_output_valid), 128'd0);
        end
        op("abort_readback", 1'b1, 32'h0000_0014, '0, c_E);
        op("post_write", 1'b0, 32'h0000_0014, c_F, c_E);
        op("post_read1", 1'b1, 32'h0000_0014, '0, c_F);
        op("post_read2", 1'b1, 32'h0000_0043, '0, c_P);
`ifdef LINE_MEM_STATS_EN
        chk("stats num_reads", 128'(num_reads), 128'd3);
        chk("stats num_writes", 128'(num_writes), 128'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
